// File: rtl/comp_fprint_store_pkg.sv
// comp_fprint_store_pkg: shared sizes and types for the fingerprint store
package comp_fprint_store_pkg;
  localparam int CRC_KEY_SIZE = 16;
  localparam int CRC_KEY_WIDTH = 4;
  localparam int CRC_WIDTH = 32;
  localparam int DEPTH_LOG2 = 3;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CRC_KEY_WIDTH-1:0] key_t;
  typedef logic [CRC_WIDTH-1:0] crc_t;
endpackage

// File: rtl/comp_fprint_store_if.sv
// comp_fprint_store_if: core, comparator and software signals of the fingerprint store
interface comp_fprint_store_if;
  import comp_fprint_store_pkg::*;
  logic core0_write, core1_write, core0_checkin, core1_checkin;
  key_t core0_task, core1_task, comp_task;
  crc_t core0_data, core1_data, fprint0, fprint1;
  logic head0_matches_head1, tail0_matches_head0, tail1_matches_head1;
  logic [CRC_KEY_SIZE-1:0] fprints_ready, checkin, status_clear, status_done, status_fail, overflow;
  logic comp_increment_tail_pointer, comp_reset_fprint_ready, reset_fprint_ack;
  logic comp_task_verified, fprint_reg_ack, comp_status_write, comp_status_ack, comp_mismatch_detected;
  modport master(
    output core0_write, core1_write, core0_checkin, core1_checkin, core0_task, core1_task, core0_data, core1_data,
    output comp_task, comp_increment_tail_pointer, comp_reset_fprint_ready, comp_task_verified,
    output comp_status_write, comp_mismatch_detected, status_clear,
    input fprint0, fprint1, head0_matches_head1, tail0_matches_head0, tail1_matches_head1,
    input fprints_ready, checkin, reset_fprint_ack, fprint_reg_ack, comp_status_ack,
    input status_done, status_fail, overflow
  );
  modport slave(
    input core0_write, core1_write, core0_checkin, core1_checkin, core0_task, core1_task, core0_data, core1_data,
    input comp_task, comp_increment_tail_pointer, comp_reset_fprint_ready, comp_task_verified,
    input comp_status_write, comp_mismatch_detected, status_clear,
    output fprint0, fprint1, head0_matches_head1, tail0_matches_head0, tail1_matches_head1,
    output fprints_ready, checkin, reset_fprint_ack, fprint_reg_ack, comp_status_ack,
    output status_done, status_fail, overflow
  );
endinterface

// File: rtl/comp_fprint_store_ack_gen.sv
// fprint_ack_gen: one single-cycle ack per request, however long the request is held
module fprint_ack_gen (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic ack
);
  logic seen;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ack <= 1'b0;
      seen <= 1'b0;
    end else begin
      ack <= req & ~seen;
      seen <= req;
    end
endmodule

// File: rtl/comp_fprint_store.sv
// comp_fprint_store: per-task, per-core fingerprint queues serving the comparator FSM
module comp_fprint_store
  import comp_fprint_store_pkg::*;
(
  input logic clk,
  input logic reset,
  comp_fprint_store_if.slave bus
);
  crc_t mem [CRC_KEY_SIZE][2][2**DEPTH_LOG2];
  ptr_t head [CRC_KEY_SIZE][2], tail [CRC_KEY_SIZE][2], hn [CRC_KEY_SIZE][2], tn [CRC_KEY_SIZE][2];
  logic [1:0] ci [CRC_KEY_SIZE], cn [CRC_KEY_SIZE];
  logic [CRC_KEY_SIZE-1:0] rdy, done, fail, ov, rdy_n, done_n, fail_n, ov_n, ck_all;
  logic [1:0] wr, ck, acc, full, fl;
  key_t wt [2];
  crc_t wd [2], fp0, fp1;
  logic r_ack, v_ack, s_ack;
  fprint_ack_gen u_rst_ack (.clk(clk), .reset(reset), .req(bus.comp_reset_fprint_ready), .ack(r_ack));
  fprint_ack_gen u_ver_ack (.clk(clk), .reset(reset), .req(bus.comp_task_verified), .ack(v_ack));
  fprint_ack_gen u_sts_ack (.clk(clk), .reset(reset), .req(bus.comp_status_write), .ack(s_ack));
  always_comb begin
    wr = {bus.core1_write, bus.core0_write};
    ck = {bus.core1_checkin, bus.core0_checkin};
    wt[0] = bus.core0_task;
    wt[1] = bus.core1_task;
    wd[0] = bus.core0_data;
    wd[1] = bus.core1_data;
    hn = head;
    tn = tail;
    cn = ci;
    ov_n = ov;
    for (int c = 0; c < 2; c++) begin
      fl[c] = v_ack && wt[c] == bus.comp_task;
      full[c] = ptr_t'(head[wt[c]][c] + 1'b1) == tail[wt[c]][c];
      acc[c] = wr[c] && !full[c] && !fl[c];
      if (acc[c]) hn[wt[c]][c] = head[wt[c]][c] + 1'b1;
      if (wr[c] && full[c] && !fl[c]) ov_n[wt[c]] = 1'b1;
      if (ck[c] && !fl[c]) cn[wt[c]][c] = 1'b1;
      if (bus.comp_increment_tail_pointer) tn[bus.comp_task][c] = tail[bus.comp_task][c] + 1'b1;
      // a flush overrides any same-cycle write or increment on the flushed task
      if (v_ack) begin
        hn[bus.comp_task][c] = '0;
        tn[bus.comp_task][c] = '0;
      end
    end
    if (v_ack) cn[bus.comp_task] = '0;
    for (int t = 0; t < CRC_KEY_SIZE; t++) begin
      rdy_n[t] = (rdy[t] || (((acc[0] && wt[0] == key_t'(t)) || (acc[1] && wt[1] == key_t'(t)))
                  && hn[t][0] != tn[t][0] && hn[t][1] != tn[t][1]))
                 && !((r_ack || v_ack) && bus.comp_task == key_t'(t));
      done_n[t] = (s_ack && bus.comp_task == key_t'(t)) ? 1'b1 : done[t] & ~bus.status_clear[t];
      fail_n[t] = (s_ack && bus.comp_task == key_t'(t)) ? bus.comp_mismatch_detected : fail[t] & ~bus.status_clear[t];
      ck_all[t] = &ci[t];
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head <= '{default: '0};
      tail <= '{default: '0};
      ci <= '{default: '0};
      rdy <= '0;
      done <= '0;
      fail <= '0;
      ov <= '0;
      fp0 <= '0;
      fp1 <= '0;
    end else begin
      head <= hn;
      tail <= tn;
      ci <= cn;
      rdy <= rdy_n;
      done <= done_n;
      fail <= fail_n;
      ov <= ov_n;
      fp0 <= mem[bus.comp_task][0][tail[bus.comp_task][0]];
      fp1 <= mem[bus.comp_task][1][tail[bus.comp_task][1]];
    end
  always_ff @(posedge clk)
    for (int c = 0; c < 2; c++)
      if (acc[c]) mem[wt[c]][c][head[wt[c]][c]] <= wd[c];
  assign bus.fprint0 = fp0;
  assign bus.fprint1 = fp1;
  assign bus.head0_matches_head1 = head[bus.comp_task][0] == head[bus.comp_task][1];
  assign bus.tail0_matches_head0 = tail[bus.comp_task][0] == head[bus.comp_task][0];
  assign bus.tail1_matches_head1 = tail[bus.comp_task][1] == head[bus.comp_task][1];
  assign bus.fprints_ready = rdy;
  assign bus.checkin = ck_all;
  assign bus.status_done = done;
  assign bus.status_fail = fail;
  assign bus.overflow = ov;
  assign bus.reset_fprint_ack = r_ack;
  assign bus.fprint_reg_ack = v_ack;
  assign bus.comp_status_ack = s_ack;
endmodule

// File: tb/tb_comp_fprint_store.sv
// tb_comp_fprint_store: directed test-plan cases plus random traffic against a queue-based model
module tb_comp_fprint_store;
  import comp_fprint_store_pkg::*;
  logic clk = 1'b0;
  logic reset;
  comp_fprint_store_if bus ();
  comp_fprint_store dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  crc_t q [CRC_KEY_SIZE][2][$];
  int wc [CRC_KEY_SIZE][2];
  logic [CRC_KEY_SIZE-1:0] m_rdy, m_done, m_fail, m_ov;
  logic [1:0] m_ci [CRC_KEY_SIZE];
  bit m_ack [3], m_seen [3], fv [2];
  crc_t fx [2];
  int acks;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < CRC_KEY_SIZE; t++) begin
      for (int c = 0; c < 2; c++) begin
        q[t][c].delete();
        wc[t][c] = 0;
      end
      m_ci[t] = 2'b00;
    end
    m_rdy = '0; m_done = '0; m_fail = '0; m_ov = '0;
    for (int i = 0; i < 3; i++) begin m_ack[i] = 0; m_seen[i] = 0; end
    fv[0] = 0; fv[1] = 0;
  endtask

  // Apply one clock edge worth of the specified behaviour to the model, using pre-edge state
  task automatic model_edge();
    bit [1:0] wr, ck;
    int tk [2];
    crc_t d [2];
    bit [2:0] req;
    bit [CRC_KEY_SIZE-1:0] touched = '0;
    int ct = int'(bus.comp_task);
    bit flush = m_ack[1];
    wr = {bus.core1_write, bus.core0_write};
    ck = {bus.core1_checkin, bus.core0_checkin};
    tk[0] = int'(bus.core0_task); tk[1] = int'(bus.core1_task);
    d[0] = bus.core0_data; d[1] = bus.core1_data;
    for (int c = 0; c < 2; c++) begin
      fv[c] = q[ct][c].size() > 0;
      if (fv[c]) fx[c] = q[ct][c][0];
    end
    for (int c = 0; c < 2; c++) begin
      if (wr[c] && !(flush && tk[c] == ct)) begin
        if (q[tk[c]][c].size() == 7) m_ov[tk[c]] = 1'b1;
        else begin
          q[tk[c]][c].push_back(d[c]);
          wc[tk[c]][c]++;
          touched[tk[c]] = 1'b1;
        end
      end
      if (ck[c] && !(flush && tk[c] == ct)) m_ci[tk[c]][c] = 1'b1;
    end
    if (bus.comp_increment_tail_pointer && !flush)
      for (int c = 0; c < 2; c++) if (q[ct][c].size() > 0) void'(q[ct][c].pop_front());
    for (int t = 0; t < CRC_KEY_SIZE; t++)
      if (touched[t] && q[t][0].size() > 0 && q[t][1].size() > 0) m_rdy[t] = 1'b1;
    if (m_ack[0] || m_ack[1]) m_rdy[ct] = 1'b0;
    if (flush) begin
      for (int c = 0; c < 2; c++) begin q[ct][c].delete(); wc[ct][c] = 0; end
      m_ci[ct] = 2'b00;
    end
    m_done &= ~bus.status_clear;
    m_fail &= ~bus.status_clear;
    if (m_ack[2]) begin m_done[ct] = 1'b1; m_fail[ct] = bus.comp_mismatch_detected; end
    req = {bus.comp_status_write, bus.comp_task_verified, bus.comp_reset_fprint_ready};
    for (int i = 0; i < 3; i++) begin m_ack[i] = req[i] && !m_seen[i]; m_seen[i] = req[i]; end
  endtask

  task automatic check_all();
    int ct = int'(bus.comp_task);
    logic [CRC_KEY_SIZE-1:0] civ;
    for (int t = 0; t < CRC_KEY_SIZE; t++) civ[t] = &m_ci[t];
    chk("fprints_ready", bus.fprints_ready, m_rdy);
    chk("checkin", bus.checkin, civ);
    chk("status_done", bus.status_done, m_done);
    chk("status_fail", bus.status_fail, m_fail);
    chk("overflow", bus.overflow, m_ov);
    chk("acks", {bus.comp_status_ack, bus.fprint_reg_ack, bus.reset_fprint_ack}, {m_ack[2], m_ack[1], m_ack[0]});
    chk("head0_matches_head1", bus.head0_matches_head1, (wc[ct][0] % 8) == (wc[ct][1] % 8));
    chk("tail0_matches_head0", bus.tail0_matches_head0, q[ct][0].size() == 0);
    chk("tail1_matches_head1", bus.tail1_matches_head1, q[ct][1].size() == 0);
    if (fv[0]) chk("fprint0", bus.fprint0, fx[0]);
    if (fv[1]) chk("fprint1", bus.fprint1, fx[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_fprints"}, {bus.fprint0, bus.fprint1}, 64'd0);
    chk({tag, "_flags"}, {bus.fprints_ready, bus.checkin, bus.status_done, bus.status_fail}, 64'd0);
    chk({tag, "_ovf_acks"}, {bus.overflow, bus.reset_fprint_ack, bus.fprint_reg_ack, bus.comp_status_ack}, 64'd0);
    chk({tag, "_matches"}, {bus.head0_matches_head1, bus.tail0_matches_head0, bus.tail1_matches_head1}, 64'h7);
  endtask

  task automatic idle();
    bus.core0_write = 0; bus.core1_write = 0; bus.core0_checkin = 0; bus.core1_checkin = 0;
    bus.comp_increment_tail_pointer = 0; bus.comp_reset_fprint_ready = 0;
    bus.comp_task_verified = 0; bus.comp_status_write = 0; bus.status_clear = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    bus.core0_task = '0; bus.core1_task = '0; bus.core0_data = '0; bus.core1_data = '0;
    bus.comp_task = '0; bus.comp_mismatch_detected = 0;
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    #3 reset = 0;

    // both cores push the same fingerprint to task 3
    bus.comp_task = 4'd3;
    bus.core0_write = 1; bus.core0_task = 4'd3; bus.core0_data = 32'hAAAA0001;
    bus.core1_write = 1; bus.core1_task = 4'd3; bus.core1_data = 32'hAAAA0001;
    step();
    chk("t3_ready", bus.fprints_ready[3], 1'b1);
    idle();
    step();
    chk("t3_fprint0", bus.fprint0, 32'hAAAA0001);
    chk("t3_fprint1", bus.fprint1, 32'hAAAA0001);
    chk("t3_h0h1", bus.head0_matches_head1, 1'b1);
    bus.comp_increment_tail_pointer = 1;
    step();
    idle();
    chk("t3_t0h0", bus.tail0_matches_head0, 1'b1);
    chk("t3_t1h1", bus.tail1_matches_head1, 1'b1);
    bus.comp_reset_fprint_ready = 1;
    repeat (2) step();
    idle();
    step();
    chk("t3_ready_cleared", bus.fprints_ready[3], 1'b0);

    // overflow on task 5
    for (int i = 0; i < 9; i++) begin
      bus.core0_write = 1; bus.core0_task = 4'd5; bus.core0_data = $urandom;
      step();
    end
    idle();
    step();
    chk("t5_overflow", bus.overflow[5], 1'b1);

    // check-in then flush of task 2 with a colliding write
    bus.core0_checkin = 1; bus.core1_checkin = 1; bus.core0_task = 4'd2; bus.core1_task = 4'd2;
    step();
    idle();
    chk("t2_checkin", bus.checkin[2], 1'b1);
    bus.comp_task = 4'd2; bus.comp_task_verified = 1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      bus.core0_write = (i == 1); bus.core0_task = 4'd2; bus.core0_data = 32'h12345678;
      step();
      acks += int'(bus.fprint_reg_ack);
    end
    idle();
    chk("t2_ack_count", acks, 1);
    chk("t2_checkin_cleared", bus.checkin[2], 1'b0);
    chk("t2_empty", bus.tail0_matches_head0, 1'b1);

    // status write on task 7 beats a simultaneous clear
    bus.comp_task = 4'd7; bus.comp_mismatch_detected = 1; bus.status_clear = 16'h0080; bus.comp_status_write = 1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin bus.status_clear = '0; bus.comp_status_write = 0; end
      step();
      acks += int'(bus.comp_status_ack);
    end
    chk("t7_ack_count", acks, 1);
    chk("t7_done", bus.status_done[7], 1'b1);
    chk("t7_fail", bus.status_fail[7], 1'b1);

    // random traffic on a few tasks
    for (int n = 0; n < 3000; n++) begin
      int ct;
      bus.core0_write = $urandom_range(0, 2) == 0; bus.core0_task = 4'($urandom_range(0, 3)); bus.core0_data = $urandom;
      bus.core1_write = $urandom_range(0, 2) == 0; bus.core1_task = 4'($urandom_range(0, 3)); bus.core1_data = $urandom;
      bus.core0_checkin = $urandom_range(0, 15) == 0;
      bus.core1_checkin = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 15) == 0) bus.comp_task = 4'($urandom_range(0, 3));
      ct = int'(bus.comp_task);
      bus.comp_increment_tail_pointer = $urandom_range(0, 2) == 0 && q[ct][0].size() > 0 && q[ct][1].size() > 0;
      if ($urandom_range(0, 7) == 0) bus.comp_reset_fprint_ready = ~bus.comp_reset_fprint_ready;
      if ($urandom_range(0, 19) == 0) bus.comp_task_verified = ~bus.comp_task_verified;
      if ($urandom_range(0, 7) == 0) bus.comp_status_write = ~bus.comp_status_write;
      bus.comp_mismatch_detected = $urandom_range(0, 1) == 1;
      bus.status_clear = $urandom_range(0, 7) == 0 ? 16'(1) << $urandom_range(0, 15) : '0;
      step();
    end
    idle();
    step();

    // reset in the middle of a handshake
    bus.comp_task_verified = 1;
    step();
    #2 reset = 1;
    #1;
    check_zero("midreset");
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      acks += int'(bus.fprint_reg_ack) + int'(bus.reset_fprint_ack) + int'(bus.comp_status_ack);
    end
    chk("post_reset_acks", acks, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
